// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pkg: shared control-bundle layout, field indices and MIPS opcode/funct constants for ctrl_pipe (MDU decode gated by CTRL_PIPE_MDU_EN)
package ctrl_pkg;
  localparam int CTL_W = 18;
  localparam int B_REGWRITE = 0;
  localparam int B_MEMTOREG = 1;
  localparam int B_MEMWRITE = 2;
  localparam int B_SW = 3;
  localparam int B_SH = 4;
  localparam int B_SB = 5;
  localparam int B_JAL = 6;
  localparam int B_JALR = 7;
  localparam int B_BGEZAL = 8;
  localparam int B_MULT = 9;
  localparam int B_DIV = 10;
  localparam int B_MFHI = 11;
  localparam int B_MFLO = 12;
  localparam int B_WA = 13;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI = 6'h0d;
  localparam logic [5:0] OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LB = 6'h20;
  localparam logic [5:0] OP_LH = 6'h21;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB = 6'h28;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SW = 6'h2b;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV = 6'h1a;
  localparam logic [5:0] FN_DIVU = 6'h1b;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_OR = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;
  typedef struct packed {
    logic [4:0] wa;
    logic mflo;
    logic mfhi;
    logic div;
    logic mult;
    logic bgezal;
    logic jalr;
    logic jal;
    logic sb;
    logic sh;
    logic sw;
    logic memwrite;
    logic memtoreg;
    logic regwrite;
  } ctl_t;
endpackage

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: D-stage instruction/stall inputs and per-stage control bundle outputs of ctrl_pipe
interface ctrl_pipe_if import ctrl_pkg::*; #(parameter int STAGES = 3);
  logic [31:0] instr_D;
  logic stall_i;
  logic [STAGES*CTL_W-1:0] ctl_o;
  logic md_busy_o;
  logic md_stall_o;
  modport master(output instr_D, stall_i, input ctl_o, md_busy_o, md_stall_o);
  modport slave(input instr_D, stall_i, output ctl_o, md_busy_o, md_stall_o);
endinterface

// File: rtl/ctrl_pipe_decode.sv
// ctrl_decode: combinational instruction to control bundle decoder (mult/div/mfhi/mflo only with CTRL_PIPE_MDU_EN)
module ctrl_decode import ctrl_pkg::*; (
  input logic [31:0] instr,
  output ctl_t ctl
);
  logic [5:0] op, fn;
  logic [4:0] rt, rd, wa;
  logic rw;
  logic unused_bits;
  ctl_t c;
  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign unused_bits = ^{instr[25:21], instr[10:6]};
  // decode raw fields, then enforce the regwrite/wa consistency rules
  always_comb begin
    c = '0;
    rw = 1'b0;
    wa = '0;
    case (op)
      OP_RTYPE:
        case (fn)
          FN_ADDU, FN_SUBU, FN_OR, FN_SLT, FN_SLTU, FN_SLLV, FN_SRAV, FN_SRLV, FN_SRA: begin
            rw = 1'b1;
            wa = rd;
          end
          FN_JALR: begin
            rw = 1'b1;
            wa = rd;
            c.jalr = 1'b1;
          end
`ifdef CTRL_PIPE_MDU_EN
          FN_MULT, FN_MULTU: c.mult = 1'b1;
          FN_DIV, FN_DIVU: c.div = 1'b1;
          FN_MFHI: begin
            rw = 1'b1;
            wa = rd;
            c.mfhi = 1'b1;
          end
          FN_MFLO: begin
            rw = 1'b1;
            wa = rd;
            c.mflo = 1'b1;
          end
`endif
          default: ;
        endcase
      OP_ORI, OP_LUI, OP_ADDI: begin
        rw = 1'b1;
        wa = rt;
      end
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
        rw = 1'b1;
        wa = rt;
        c.memtoreg = 1'b1;
      end
      OP_SW: {c.memwrite, c.sw} = 2'b11;
      OP_SH: {c.memwrite, c.sh} = 2'b11;
      OP_SB: {c.memwrite, c.sb} = 2'b11;
      OP_JAL: begin
        rw = 1'b1;
        wa = 5'd31;
        c.jal = 1'b1;
      end
      OP_REGIMM: begin
        rw = 1'b1;
        wa = 5'd31;
        c.bgezal = 1'b1;
      end
      default: ;
    endcase
    c.regwrite = rw && wa != '0;
    c.wa = c.regwrite ? wa : '0;
  end
  assign ctl = c;
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: decode-once control bundle pipeline with bubble insertion and mult/div busy tracking (MDU enabled by CTRL_PIPE_MDU_EN)
module ctrl_pipe import ctrl_pkg::*; #(
  parameter int STAGES = 3,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  ctrl_pipe_if.slave bus
);
  localparam int W = STAGES * CTL_W;
  ctl_t dec;
  logic bubble, busy, md_stall;
  logic [W-1:0] ctl_q, ctl_d;
  ctrl_decode u_dec (.instr(bus.instr_D), .ctl(dec));
  assign bubble = bus.stall_i | md_stall;
  // stage 0 takes the decoded bundle or a bubble; later stages always shift
  always_comb ctl_d = {ctl_q[W-CTL_W-1:0], bubble ? ctl_t'('0) : dec};
  // stage registers
  always_ff @(posedge clk) begin
    if (reset) ctl_q <= '0;
    else ctl_q <= ctl_d;
  end
`ifdef CTRL_PIPE_MDU_EN
  localparam int CW = $clog2(DIV_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic s0_mult, s0_div;
  assign s0_mult = ctl_q[B_MULT];
  assign s0_div = ctl_q[B_DIV];
  // load busy length when a mult/div sits in stage 0, otherwise count down to idle
  always_comb cnt_d = s0_mult ? CW'(MULT_CYCLES) : s0_div ? CW'(DIV_CYCLES) : cnt_q - CW'(cnt_q != '0);
  // MDU busy counter
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign busy = (cnt_q != '0) | s0_mult | s0_div;
  assign md_stall = busy & (dec.mult | dec.div | dec.mfhi | dec.mflo);
`else
  localparam int unused_cycles = MULT_CYCLES + DIV_CYCLES;
  assign busy = 1'b0;
  assign md_stall = 1'b0;
`endif
  assign bus.ctl_o = ctl_q;
  assign bus.md_busy_o = busy;
  assign bus.md_stall_o = md_stall;
endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised control-bundle pipeline for the MIPS core. It decodes the instruction in D once into a fixed control bundle and carries that bundle through STAGES registered stages (stage 0 = E, stage 1 = M, stage 2 = W by default), so per-stage decoders are no longer needed. It inserts bubbles on external stall and tracks a multi-cycle mult/div unit, raising its own hazard stall for dependent HI/LO instructions.

## Interface
Parameters:
- STAGES, 3, number of registered stages (≥2); stage 0 is E.
- MULT_CYCLES, 5, mult/multu busy length in cycles (≥1).
- DIV_CYCLES, 10, div/divu busy length in cycles (≥1).

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state on the edge where it is sampled high.
- instr_D  in  32  instruction currently in D.
- stall_i  in  1  external hazard stall (load-use, branch); forces a bubble into stage 0.
- ctl_o  out  STAGES*CTL_W  packed bundles; slice k = stage k.
- md_busy_o  out  1  mult/div unit busy.
- md_stall_o  out  1  HI/LO hazard; OR into the D/F freeze externally.

## Operation
- Bundle fields, CTL_W=18, LSB first: regwrite, memtoreg, memwrite, sw, sh, sb, jal, jalr, bgezal, mult, div, mfhi, mflo, wa[4:0].
- Decode: R-type (op 0) addu/subu/or/slt/sltu/sllv/srav/srlv/sra, mfhi, mflo, jalr -> regwrite, wa=rd; mult/div set only their flag. ori/lui/addi -> regwrite, wa=rt. lw/lh/lhu/lb/lbu -> regwrite, memtoreg, wa=rt. sw/sh/sb -> memwrite plus size flag. jal -> jal, regwrite, wa=31. op 000001 (bgezal) -> bgezal, regwrite, wa=31.
- Every field is defined for every opcode. Unsupported encodings produce an all-zero bundle.
- If wa==0, regwrite is forced 0, and wa is forced 0 whenever regwrite=0.
- Advance each cycle: stage 0 ← decode(instr_D), or all-zero if bubble=stall_i|md_stall_o; stage k ← stage k-1. Later stages never freeze.
- MDU counter cnt, width $clog2(DIV_CYCLES+1):
  - When stage 0 holds mult, cnt ← MULT_CYCLES; when stage 0 holds div, cnt ← DIV_CYCLES.
  - Otherwise cnt decrements while nonzero.
- md_busy_o = (cnt≠0) | stage0.mult | stage0.div.
- md_stall_o = md_busy_o & decode(instr_D) is mult/div/mfhi/mflo.
- A new mult/div entering stage 0 while busy cannot happen, because md_stall_o blocks it.

## Timing
- Reset: all stages zero, cnt=0, md_busy_o=0, md_stall_o=0 (decode of instr_D is still combinational but gated by busy=0).
- Latency: instr_D at cycle t appears in slice 0 at t+1 and in slice k at t+1+k.
- Mult in stage 0 at cycle t: md_busy_o is high for cycles t..t+MULT_CYCLES (MULT_CYCLES+1 cycles) and low at t+MULT_CYCLES+1. The same holds for div with DIV_CYCLES.
- If stall_i and md_stall_o are both high, a single bubble is inserted. Both signals have identical effect.
- Reset mid-operation: the counter and all stages clear on the same edge, and md_busy_o is 0 the following cycle.
- Outputs ctl_o and md_busy_o are registered-derived. md_stall_o is combinational from instr_D.

## Configuration
- CTRL_PIPE_MDU_EN defined: mult/div/mfhi/mflo decode, counter and md_busy_o/md_stall_o behave as above.
- CTRL_PIPE_MDU_EN undefined:
  - The four MDU opcodes decode to all-zero bundles and no counter exists.
  - md_busy_o and md_stall_o are tied to 0.
  - Bundle layout and CTL_W are unchanged.

## Structure
- Shared package ctrl_pkg holds:
  - CTL_W and the field bit-index constants.
  - Opcode and funct localparams.
  - A packed struct ctl_t matching the bit layout.
- Sub-module ctrl_decode: purely combinational instr -> ctl_t, reused by the hazard unit. ctrl_pipe instantiates it once on instr_D.

## Test plan
- addu $3,$1,$2 (0x00221821) at t, no stall -> slice 0 at t+1 has regwrite=1, wa=3; the identical bundle is in slice 2 at t+3.
- jal (0x0C000010) -> jal=1, regwrite=1, wa=31. lw $5,0($0) (0x8C050000) -> memtoreg=1, regwrite=1, wa=5. sh (0xA4050000) -> memwrite=1, sh=1, regwrite=0.
- addu $0,$0,$0 (0x00000021) -> regwrite=0, wa=0. Undefined op 0x3F -> all-zero bundle.
- mult (0x00220018) followed by mflo $4 (0x00002012), MULT_CYCLES=5 -> md_stall_o high 6 consecutive cycles with bubbles entering slice 0; mflo enters slice 0 in the cycle after md_stall_o drops.
- stall_i pulsed for 2 cycles with ori in D -> slice 0 zero for 2 cycles, then ori; downstream slices keep advancing.
- div in flight with reset at cycle 3 -> next cycle cnt=0, md_busy_o=0, all slices zero. With CTRL_PIPE_MDU_EN undefined, mult decodes to zero and md_busy_o stays 0.
